// File: rtl/tt_logic_combiner.sv
// tt_logic_combiner: N-channel synchronise + debounce front end feeding a
// run-time selectable combine (OR/AND/XOR/majority), registered output,
// rising-edge pulse and saturating rising-edge counter.

// Per-channel two-flop synchroniser and debounce filter.
module tt_logic_combiner_lane #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in_raw,
  output logic deb
);
  localparam int DCW = $clog2(DB_CYCLES) + 1;

  logic           s1_q, s1_d;
  logic           s2_q, s2_d;
  logic           deb_q, deb_d;
  logic [DCW-1:0] dc_q, dc_d;

  // Sync chain, then accept s2 only after it has differed from deb for DB_CYCLES evaluations.
  always_comb begin
    s1_d  = in_raw;
    s2_d  = s1_q;
    deb_d = deb_q;
    dc_d  = dc_q;
    if (s2_q == deb_q) begin
      dc_d = '0;
    end else if (dc_q == DCW'(DB_CYCLES - 1)) begin
      deb_d = s2_q;
      dc_d  = '0;
    end else begin
      dc_d = dc_q + DCW'(1);
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      deb_q <= 1'b0;
      dc_q  <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      deb_q <= deb_d;
      dc_q  <= dc_d;
    end
  end

  assign deb = deb_q;
endmodule

module tt_logic_combiner #(
  parameter int N_IN      = 8,
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  in,
  input  logic [N_IN-1:0]  mask,
  input  logic [1:0]       mode,
  input  logic             cnt_clr,
  output logic             out,
  output logic             rise,
  output logic [CNT_W-1:0] count,
  output logic [N_IN-1:0]  stable
);
  localparam int PW = $clog2(N_IN + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_IN-1:0] deb;
  logic [N_IN-1:0] m;
  logic [PW-1:0]   pc_m, pc_k;
  logic            comb;

  for (genvar g = 0; g < N_IN; g++) begin : g_lane
    tt_logic_combiner_lane #(.DB_CYCLES(DB_CYCLES)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .in_raw (in[g]),
      .deb    (deb[g])
    );
  end

  assign m = deb & mask;

  // Popcounts of active channels and of enabled channels for majority.
  always_comb begin
    pc_m = '0;
    pc_k = '0;
    for (int i = 0; i < N_IN; i++) begin
      pc_m = pc_m + PW'(m[i]);
      pc_k = pc_k + PW'(mask[i]);
    end
  end

  // Combine function; masked-off channels are transparent to AND and absent elsewhere.
  always_comb begin
    comb = 1'b0;
    case (mode)
      2'd0:    comb = |m;
      2'd1:    comb = &(deb | ~mask);
      2'd2:    comb = ^m;
      default: comb = ({pc_m, 1'b0} > {1'b0, pc_k});
    endcase
  end

  logic             out_q, out_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next output, edge pulse and saturating counter; clear wins over a pending rise.
  always_comb begin
    out_d   = comb;
    rise_d  = comb & ~out_q;
    count_d = count_q;
    if (cnt_clr)
      count_d = '0;
    else if (rise_q && (count_q != CNT_MAX))
      count_d = count_q + CNT_W'(1);
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
      count_q <= '0;
    end else begin
      out_q   <= out_d;
      rise_q  <= rise_d;
      count_q <= count_d;
    end
  end

  assign out    = out_q;
  assign rise   = rise_q;
  assign count  = count_q;
  assign stable = deb;
endmodule

// File: tb/tb_tt_logic_combiner.sv
// Bench for tt_logic_combiner: directed scenarios followed by random traffic,
// every cycle checked against a window-based behavioural model.
// Edge numbering in directed steps: edge 0 is the first edge that samples
// the newly applied input.
module tb_tt_logic_combiner;
  localparam int N  = 4;
  localparam int DB = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  din, msk;
  logic [1:0]    md;
  logic          clr;
  logic          out_o, rise_o;
  logic [CW-1:0] count_o;
  logic [N-1:0]  stable_o;

  int total = 0;
  int bad   = 0;

  tt_logic_combiner #(.N_IN(N), .DB_CYCLES(DB), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .in      (din),
    .mask    (msk),
    .mode    (md),
    .cnt_clr (clr),
    .out     (out_o),
    .rise    (rise_o),
    .count   (count_o),
    .stable  (stable_o)
  );

  always #5 clk = ~clk;

  // Model: history of applied inputs and of synchronised samples since reset.
  logic [N-1:0]  hist[$];
  logic [N-1:0]  s2w[$];
  logic [N-1:0]  deb_m;
  logic          out_m, rise_m;
  logic [CW-1:0] count_m;

  function automatic logic comb_f(input logic [N-1:0] d, input logic [N-1:0] k, input logic [1:0] mo);
    logic [N-1:0] mm;
    mm = d & k;
    case (mo)
      2'd0:    return mm != '0;
      2'd1:    return mm == k;
      2'd2:    return ($countones(mm) % 2) == 1;
      default: return 2 * $countones(mm) > $countones(k);
    endcase
  endfunction

  task automatic model_reset();
    hist.delete();
    s2w.delete();
    deb_m   = '0;
    out_m   = 1'b0;
    rise_m  = 1'b0;
    count_m = '0;
  endtask

  task automatic model_edge();
    int t, sz;
    logic [N-1:0] s2v;
    logic c, all;
    t   = hist.size();
    s2v = (t >= 2) ? hist[t-2] : '0;
    hist.push_back(din);
    s2w.push_back(s2v);
    c = comb_f(deb_m, msk, md);
    if (clr) count_m = '0;
    else if (rise_m && count_m != {CW{1'b1}}) count_m = count_m + 1'b1;
    rise_m = c & ~out_m;
    out_m  = c;
    // A channel flips once its last DB synchronised samples all disagree with it.
    sz = s2w.size();
    if (sz >= DB) begin
      for (int i = 0; i < N; i++) begin
        all = 1'b1;
        for (int k = 1; k <= DB; k++)
          if (s2w[sz-k][i] == deb_m[i]) all = 1'b0;
        if (all) deb_m[i] = ~deb_m[i];
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("m_stable", 32'(stable_o), 32'(deb_m));
    chk("m_out",    32'(out_o),    32'(out_m));
    chk("m_rise",   32'(rise_o),   32'(rise_m));
    chk("m_count",  32'(count_o),  32'(count_m));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    @(negedge clk);
    check_model();
  endtask

  initial begin
    logic saw;
    rst = 1'b1; din = '0; msk = '0; md = 2'd0; clr = 1'b0;
    model_reset();
    step(); step();
    chk("rst_out",    32'(out_o),    0);
    chk("rst_rise",   32'(rise_o),   0);
    chk("rst_count",  32'(count_o),  0);
    chk("rst_stable", 32'(stable_o), 0);

    // Basic latency with OR.
    rst = 1'b0; md = 2'd0; msk = 4'h3; din = 4'h1;
    for (int e = 0; e <= 7; e++) begin
      step();
      if (e == 4) chk("lat_stable_pre", 32'(stable_o[0]), 0);
      if (e == 5) begin chk("lat_stable", 32'(stable_o[0]), 1); chk("lat_out_pre", 32'(out_o), 0); end
      if (e == 6) begin chk("lat_out", 32'(out_o), 1); chk("lat_rise", 32'(rise_o), 1); end
      if (e == 7) begin chk("lat_rise_end", 32'(rise_o), 0); chk("lat_count", 32'(count_o), 1); end
    end

    // Glitch rejection then accepted minimum pulse.
    din = 4'h0;
    repeat (8) step();
    clr = 1'b1; step(); clr = 1'b0;
    din = 4'h1; repeat (3) step(); din = 4'h0;
    repeat (10) begin
      step();
      chk("gl_stable", 32'(stable_o), 0);
      chk("gl_out", 32'(out_o), 0);
    end
    chk("gl_count", 32'(count_o), 0);
    din = 4'h1; repeat (4) step(); din = 4'h0;
    saw = 1'b0;
    repeat (12) begin step(); if (stable_o[0]) saw = 1'b1; end
    chk("pulse_seen", 32'(saw), 1);
    chk("pulse_count", 32'(count_o), 1);
    chk("pulse_stable_end", 32'(stable_o), 0);

    // Mode sweep on deb=1011.
    din = 4'b1011; md = 2'd0; msk = 4'hF;
    repeat (8) step();
    chk("sw_or", 32'(out_o), 1);
    md = 2'd1; step(); chk("sw_and", 32'(out_o), 0);
    msk = 4'hB; step(); chk("sw_and_mB", 32'(out_o), 1);
    md = 2'd2; msk = 4'hF; step(); chk("sw_xor", 32'(out_o), 1);
    md = 2'd3; step(); chk("sw_maj", 32'(out_o), 1);
    din = 4'b0011; repeat (8) step(); chk("sw_maj_tie", 32'(out_o), 0);

    // All channels masked.
    msk = 4'h0; md = 2'd1;
    step(); chk("am_and", 32'(out_o), 1); chk("am_and_rise", 32'(rise_o), 1);
    step(); chk("am_and_rise_end", 32'(rise_o), 0);
    md = 2'd0; step(); chk("am_or", 32'(out_o), 0);
    md = 2'd2; step(); chk("am_xor", 32'(out_o), 0);
    md = 2'd3; step(); chk("am_maj", 32'(out_o), 0);

    // Counter saturation, then clear colliding with a rise.
    clr = 1'b1; step(); clr = 1'b0;
    md = 2'd1;
    for (int i = 0; i < 5; i++) begin
      msk = 4'h0; step(); chk("sat_rise", 32'(rise_o), 1);
      msk = 4'hF; step(); chk("sat_count", 32'(count_o), (i + 1 > 3) ? 3 : i + 1);
    end
    msk = 4'h0; step(); chk("clr_rise", 32'(rise_o), 1);
    clr = 1'b1; msk = 4'hF; step(); chk("clr_wins", 32'(count_o), 0);
    clr = 1'b0;

    // Reset in the middle of a debounce.
    md = 2'd0; msk = 4'h3; din = 4'b0010;
    repeat (8) step();
    chk("pre_rst_out", 32'(out_o), 1);
    din = 4'b0011; repeat (4) step();
    rst = 1'b1; #1;
    chk("mid_rst_out",    32'(out_o),    0);
    chk("mid_rst_rise",   32'(rise_o),   0);
    chk("mid_rst_count",  32'(count_o),  0);
    chk("mid_rst_stable", 32'(stable_o), 0);
    model_reset();
    step(); step();
    rst = 1'b0;
    for (int e = 0; e <= 7; e++) begin
      step();
      if (e == 5) chk("rr_out_pre", 32'(out_o), 0);
      if (e == 6) begin chk("rr_out", 32'(out_o), 1); chk("rr_rise", 32'(rise_o), 1); end
      if (e == 7) begin chk("rr_rise_end", 32'(rise_o), 0); chk("rr_count", 32'(count_o), 1); end
    end

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 4) == 0) din[i] = ~din[i];
      if ($urandom_range(0, 29) == 0) md  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) msk = N'($urandom_range(0, 15));
      clr = ($urandom_range(0, 39) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
